// File: rtl/spi_slave_core.sv
// SPI slave transfer engine: oversamples SCLK/CS_n/MOSI in the i_clk domain, shifts
// words in and out per CPOL/CPHA, and exchanges whole words over valid/ready.
module spi_slave_core #(
    parameter int DATA_W = 8
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_cpol,
    input  logic              i_cpha,
    input  logic              i_lsb_first,
    input  logic              i_sclk,
    input  logic              i_cs_n,
    input  logic              i_mosi,
    output logic              o_miso,
    output logic              o_miso_oe,
    input  logic [DATA_W-1:0] i_tx_data,
    input  logic              i_tx_valid,
    output logic              o_tx_ready,
    output logic [DATA_W-1:0] o_rx_data,
    output logic              o_rx_valid,
    output logic              o_tx_underrun,
    output logic              o_busy
);
    localparam int CW = $clog2(DATA_W);

    typedef enum logic {S_IDLE = 1'b0, S_ACTIVE = 1'b1} state_t;

    state_t            r_state, w_state_nxt;
    logic [2:0]        r_sclk_sync;
    logic [1:0]        r_cs_sync;
    logic [1:0]        r_mosi_sync;
    logic [1:0]        r_sync_fill;
    logic              r_cs_hi;
    logic              r_cpol, r_cpha, r_lsb;
    logic [CW-1:0]     r_bit_cnt;
    logic [DATA_W-1:0] r_rx_sh, r_rx_data, r_tx_sh, r_hold;
    logic              r_hold_full, r_rx_valid, r_tx_underrun;
    logic              r_show, r_skip;

    logic              w_cs_s, w_mosi_s, w_rise, w_fall, w_lead, w_trail;
    logic              w_sample_e, w_shift_e, w_start, w_stop, w_word_done, w_load;
    logic              w_cpha_ld, w_miso_bit;
    logic [DATA_W-1:0] w_rx_next, w_tx_shifted;

    assign w_cs_s   = r_cs_sync[1];
    assign w_mosi_s = r_mosi_sync[1];
    assign w_rise   = r_sclk_sync[1] & ~r_sclk_sync[2];
    assign w_fall   = ~r_sclk_sync[1] & r_sclk_sync[2];
    assign w_lead   = r_cpol ? w_fall : w_rise;
    assign w_trail  = r_cpol ? w_rise : w_fall;

    assign w_start     = (r_state == S_IDLE) && r_cs_hi && !w_cs_s;
    assign w_stop      = (r_state == S_ACTIVE) && w_cs_s;
    assign w_sample_e  = (r_state == S_ACTIVE) && !w_cs_s && (r_cpha ? w_trail : w_lead);
    assign w_shift_e   = (r_state == S_ACTIVE) && !w_cs_s && (r_cpha ? w_lead : w_trail);
    assign w_word_done = w_sample_e && (r_bit_cnt == CW'(DATA_W - 1));
    assign w_load      = w_start || w_word_done;
    // Config is latched on the start cycle, so the load that cycle must use the live pin.
    assign w_cpha_ld   = w_start ? i_cpha : r_cpha;

    assign w_rx_next    = r_lsb ? {w_mosi_s, r_rx_sh[DATA_W-1:1]} : {r_rx_sh[DATA_W-2:0], w_mosi_s};
    assign w_tx_shifted = r_lsb ? {1'b0, r_tx_sh[DATA_W-1:1]} : {r_tx_sh[DATA_W-2:0], 1'b0};
    assign w_miso_bit   = r_lsb ? r_tx_sh[0] : r_tx_sh[DATA_W-1];

    assign o_rx_data     = r_rx_data;
    assign o_rx_valid    = r_rx_valid;
    assign o_tx_underrun = r_tx_underrun;
    assign o_tx_ready    = !r_hold_full;

    // r_cs_hi only tracks CS once the chain holds real pin samples, so a CS held low
    // through reset does not look like a fresh falling edge.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sclk_sync <= 3'b000;
            r_cs_sync   <= 2'b11;
            r_mosi_sync <= 2'b00;
            r_sync_fill <= 2'd0;
            r_cs_hi     <= 1'b0;
        end else begin
            r_sclk_sync <= {r_sclk_sync[1:0], i_sclk};
            r_cs_sync   <= {r_cs_sync[0], i_cs_n};
            r_mosi_sync <= {r_mosi_sync[0], i_mosi};
            if (r_sync_fill != 2'd2) r_sync_fill <= r_sync_fill + 2'd1;
            r_cs_hi     <= (r_sync_fill == 2'd2) && w_cs_s;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (w_start) w_state_nxt = S_ACTIVE;
            S_ACTIVE: if (w_stop)  w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        o_busy    = 1'b0;
        o_miso_oe = 1'b0;
        o_miso    = 1'b0;
        if (r_state == S_ACTIVE) begin
            o_busy    = 1'b1;
            o_miso_oe = 1'b1;
            o_miso    = r_show & w_miso_bit;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cpol <= 1'b0;
            r_cpha <= 1'b0;
            r_lsb  <= 1'b0;
        end else if (w_start) begin
            r_cpol <= i_cpol;
            r_cpha <= i_cpha;
            r_lsb  <= i_lsb_first;
        end
    end

    // Transmit side. r_skip swallows the shift edge that would otherwise advance a freshly
    // loaded word: the first leading edge for CPHA=1, or the trailing edge that closes
    // the previous word for CPHA=0 back-to-back transfers.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_hold        <= '0;
            r_hold_full   <= 1'b0;
            r_tx_sh       <= '0;
            r_tx_underrun <= 1'b0;
            r_show        <= 1'b0;
            r_skip        <= 1'b0;
        end else begin
            r_tx_underrun <= 1'b0;
            if (i_tx_valid && !r_hold_full) begin
                r_hold      <= i_tx_data;
                r_hold_full <= 1'b1;
            end
            if (w_load) begin
                if (r_hold_full) begin
                    r_tx_sh     <= r_hold;
                    r_hold_full <= 1'b0;
                end else begin
                    r_tx_sh       <= '0;
                    r_tx_underrun <= 1'b1;
                end
                r_show <= !w_cpha_ld;
                r_skip <= w_cpha_ld || w_word_done;
            end else if (w_shift_e) begin
                if (r_skip) begin
                    r_skip <= 1'b0;
                    r_show <= 1'b1;
                end else begin
                    r_tx_sh <= w_tx_shifted;
                end
            end
            if (w_stop) begin
                r_tx_sh <= '0;
                r_show  <= 1'b0;
                r_skip  <= 1'b0;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_bit_cnt  <= '0;
            r_rx_sh    <= '0;
            r_rx_data  <= '0;
            r_rx_valid <= 1'b0;
        end else begin
            r_rx_valid <= 1'b0;
            if (r_state != S_ACTIVE || w_stop) begin
                r_bit_cnt <= '0;
            end else if (w_sample_e) begin
                r_rx_sh <= w_rx_next;
                if (w_word_done) begin
                    r_bit_cnt  <= '0;
                    r_rx_data  <= w_rx_next;
                    r_rx_valid <= 1'b1;
                end else begin
                    r_bit_cnt <= r_bit_cnt + CW'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_spi_slave_core.sv
// Randomized bench for spi_slave_core: a bench-side SPI master drives frames, a feeder
// offers tx words, and a monitor checks every received word against a scoreboard.
module tb_spi_slave_core;
    localparam int W = 8;

    logic         i_clk = 1'b0;
    logic         i_rst = 1'b1;
    logic         i_cpol = 1'b0, i_cpha = 1'b0, i_lsb_first = 1'b0;
    logic         i_sclk = 1'b0, i_cs_n = 1'b1, i_mosi = 1'b0;
    logic [W-1:0] i_tx_data = '0;
    logic         i_tx_valid = 1'b0;
    logic         o_miso, o_miso_oe, o_tx_ready, o_rx_valid, o_tx_underrun, o_busy;
    logic [W-1:0] o_rx_data;

    spi_slave_core #(.DATA_W(W)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_cpol(i_cpol), .i_cpha(i_cpha),
        .i_lsb_first(i_lsb_first), .i_sclk(i_sclk), .i_cs_n(i_cs_n), .i_mosi(i_mosi),
        .o_miso(o_miso), .o_miso_oe(o_miso_oe), .i_tx_data(i_tx_data),
        .i_tx_valid(i_tx_valid), .o_tx_ready(o_tx_ready), .o_rx_data(o_rx_data),
        .o_rx_valid(o_rx_valid), .o_tx_underrun(o_tx_underrun), .o_busy(o_busy)
    );

    always #5 i_clk = ~i_clk;

    int n_vec = 0;
    int n_err = 0;
    int ur_cnt = 0;
    logic [W-1:0] exp_rx[$];   // scoreboard: words the master has fully sent
    logic [W-1:0] feed_q[$];   // words waiting to be offered on the tx port
    logic [W-1:0] m_tx[$];     // master (MOSI) words for the next frame
    logic [W-1:0] s_tx[$];     // slave tx words offered for the next frame

    task automatic wait_clk(input int n);
        repeat (n) @(negedge i_clk);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_miso"},     {31'd0, o_miso}, 0);
        chk({tag, "_miso_oe"},  {31'd0, o_miso_oe}, 0);
        chk({tag, "_tx_ready"}, {31'd0, o_tx_ready}, 1);
        chk({tag, "_rx_data"},  {24'd0, o_rx_data}, 0);
        chk({tag, "_rx_valid"}, {31'd0, o_rx_valid}, 0);
        chk({tag, "_underrun"}, {31'd0, o_tx_underrun}, 0);
        chk({tag, "_busy"},     {31'd0, o_busy}, 0);
    endtask

    initial begin : monitor
        logic [W-1:0] e;
        forever begin
            @(negedge i_clk);
            if (o_tx_underrun === 1'b1) ur_cnt++;
            if (o_rx_valid === 1'b1) begin
                if (exp_rx.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL rx_unexpected: got word 0x%0h, want no rx_valid (t=%0t)", o_rx_data, $time);
                end else begin
                    e = exp_rx.pop_front();
                    chk("rx_word", {24'd0, o_rx_data}, {24'd0, e});
                end
            end
        end
    end

    initial begin : feeder
        int t;
        forever begin
            @(negedge i_clk);
            if (feed_q.size() != 0 && !i_rst) begin
                t = 0;
                while (o_tx_ready !== 1'b1 && t < 3000) begin
                    @(negedge i_clk);
                    t++;
                end
                if (t >= 3000) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL tx_ready_timeout: ready=%0b, want 1 within 3000 cycles", o_tx_ready);
                    feed_q.delete();
                end else begin
                    i_tx_data  = feed_q[0];
                    i_tx_valid = 1'b1;
                    @(negedge i_clk);
                    i_tx_valid = 1'b0;
                    void'(feed_q.pop_front());
                end
            end
        end
    end

    // Bench-side master. Reference rules: word i on MISO is the i-th offered word, or 0
    // when none was offered; every word start (CS fall plus each completed word) consumes
    // one offered word or raises one underrun.
    task automatic run_frame(input bit cpol, input bit cpha, input bit lsb,
                             input int nbits, input int rst_at);
        int nfull, prov, t, w, k, idx, ur_base;
        logic [W-1:0] rxw, mw, expw;
        nfull = nbits / W;
        prov  = s_tx.size();
        i_cpol = cpol; i_cpha = cpha; i_lsb_first = lsb;
        i_sclk = cpol; i_mosi = 1'b0;
        foreach (s_tx[j]) feed_q.push_back(s_tx[j]);
        t = 0;
        while (prov > 0 && feed_q.size() > prov - 1 && t < 3000) begin
            wait_clk(1);
            t++;
        end
        if (t >= 3000) begin
            n_vec++;
            n_err++;
            $display("FAIL preload_timeout: %0d words still queued, want %0d", feed_q.size(), prov - 1);
        end
        wait_clk(2);
        ur_base = ur_cnt;
        i_cs_n = 1'b0;
        wait_clk(8);
        chk("busy_active", {31'd0, o_busy}, 1);
        chk("oe_active", {31'd0, o_miso_oe}, 1);
        if (cpha) chk("miso_before_lead", {31'd0, o_miso}, 0);
        rxw = '0;
        for (int b = 0; b < nbits; b++) begin
            w = b / W;
            k = b % W;
            idx = lsb ? k : W - 1 - k;
            mw = m_tx[w];
            if (b == rst_at) begin
                i_rst = 1'b1;
                wait_clk(1);
                chk_reset_outputs("rst_mid");
                i_rst = 1'b0;
                return;
            end
            if (!cpha) begin
                i_mosi = mw[idx];
                wait_clk(8);
                rxw[idx] = o_miso;
                if (k == W - 1) exp_rx.push_back(mw);
                i_sclk = ~cpol;
                wait_clk(8);
                i_sclk = cpol;
            end else begin
                i_sclk = ~cpol;
                i_mosi = mw[idx];
                wait_clk(8);
                rxw[idx] = o_miso;
                if (k == W - 1) exp_rx.push_back(mw);
                i_sclk = cpol;
                wait_clk(8);
            end
            if (k == W - 1) begin
                expw = (w < prov) ? s_tx[w] : '0;
                chk("miso_word", {24'd0, rxw}, {24'd0, expw});
            end
        end
        wait_clk(8);
        i_cs_n = 1'b1;
        wait_clk(2);
        chk("busy_hold_2cyc", {31'd0, o_busy}, 1);
        wait_clk(1);
        chk("busy_idle", {31'd0, o_busy}, 0);
        chk("oe_idle", {31'd0, o_miso_oe}, 0);
        chk("miso_idle", {31'd0, o_miso}, 0);
        wait_clk(8);
        chk("underruns", ur_cnt - ur_base, (1 + nfull) - prov);
    endtask

    initial begin : main
        int nw, prov, t;
        wait_clk(3);
        chk_reset_outputs("reset");
        i_rst = 1'b0;
        wait_clk(5);

        // Mode 0..3, MSB first: master sends 0x3C, slave sends 0xA5.
        for (int m = 0; m < 4; m++) begin
            m_tx = '{8'h3C};
            s_tx = '{8'hA5};
            run_frame(m[1], m[0], 1'b0, 8, -1);
        end

        // LSB first.
        m_tx = '{8'h01};
        s_tx = '{W'($urandom_range(0, 255))};
        run_frame(1'b0, 1'b0, 1'b1, 8, -1);
        m_tx = '{8'h01};
        s_tx = '{W'($urandom_range(0, 255))};
        run_frame(1'b1, 1'b1, 1'b1, 8, -1);

        // Continuous 24-bit transfer, third tx word missing.
        m_tx = '{W'($urandom_range(0, 255)), W'($urandom_range(0, 255)), W'($urandom_range(0, 255))};
        s_tx = '{8'h11, 8'h22};
        run_frame(1'b0, 1'b0, 1'b0, 24, -1);

        // Abort after 5 bits, then a clean transfer.
        m_tx = '{8'hFF};
        s_tx = '{8'h5A};
        run_frame(1'b0, 1'b1, 1'b0, 5, -1);
        m_tx = '{8'hC3};
        s_tx = '{8'h96};
        run_frame(1'b0, 1'b1, 1'b0, 8, -1);

        // Reset mid-word with CS held low: must not resume until a fresh CS fall.
        m_tx = '{8'h77};
        s_tx = '{8'h33};
        run_frame(1'b1, 1'b0, 1'b0, 8, 3);
        i_sclk = 1'b1;
        wait_clk(20);
        chk("no_resume_busy", {31'd0, o_busy}, 0);
        chk("no_resume_oe", {31'd0, o_miso_oe}, 0);
        i_cs_n = 1'b1;
        wait_clk(10);
        m_tx = '{8'hFF};
        s_tx = '{W'($urandom_range(0, 255))};
        run_frame(1'b1, 1'b0, 1'b0, 8, -1);

        // Randomized frames.
        for (int f = 0; f < 8; f++) begin
            nw = $urandom_range(1, 3);
            prov = $urandom_range(0, nw + 1);
            m_tx.delete();
            s_tx.delete();
            for (int i = 0; i < nw; i++) m_tx.push_back(W'($urandom_range(0, 255)));
            for (int i = 0; i < prov; i++) s_tx.push_back(W'($urandom_range(0, 255)));
            run_frame(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)), nw * W, -1);
        end

        t = 0;
        while (exp_rx.size() != 0 && t < 200) begin
            wait_clk(1);
            t++;
        end
        if (exp_rx.size() != 0) begin
            n_vec++;
            n_err++;
            $display("FAIL rx_missing: %0d words never received, want 0", exp_rx.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/spi_slave_core.md
# spi_slave_core

SPI slave-side transfer engine: the receiving end of the link driven by the team's master clock generator. Oversamples an externally driven SCLK/CS_n/MOSI in the local system clock domain, detects SCLK edges per CPOL/CPHA, shifts serial data in and out, and presents whole words on a valid/ready parallel interface. Sits between the SPI pads and the register/FIFO layer of a slave device.

## Interface
- DATA_W, 8, word length in bits (2..32)
- i_clk  in  1  system clock; must be ≥ 8× SCLK frequency
- i_rst  in  1  asynchronous reset, active-high
- i_cpol  in  1  SCLK idle level
- i_cpha  in  1  0: sample on leading edge, 1: sample on trailing edge
- i_lsb_first  in  1  1: LSB first on both MOSI and MISO
- i_sclk  in  1  SPI clock from master (asynchronous)
- i_cs_n  in  1  chip select, active-low (asynchronous)
- i_mosi  in  1  serial data in (asynchronous)
- o_miso  out  1  serial data out
- o_miso_oe  out  1  MISO output enable (1 while selected)
- i_tx_data  in  DATA_W  next word to transmit
- i_tx_valid  in  1  tx word offered
- o_tx_ready  out  1  tx holding register empty
- o_rx_data  out  DATA_W  last complete received word
- o_rx_valid  out  1  one-cycle pulse, o_rx_data updated
- o_tx_underrun  out  1  one-cycle pulse, word started with empty tx holding register
- o_busy  out  1  state ACTIVE

## Operation
- Synchronizers: two-flop chains on i_sclk, i_cs_n, i_mosi (reset: sclk 0, cs_n 1, mosi 0); a third sclk flop for edge detect. cs_s = synchronized cs_n.
- Leading edge = sclk_s transition away from CPOL level; trailing edge = return to CPOL. Sample edge = leading if CPHA=0 else trailing; shift edge = the other.
- i_cpol, i_cpha, i_lsb_first latched at IDLE→ACTIVE; changes while ACTIVE ignored.
- FSM states: IDLE, ACTIVE.
  - IDLE: o_miso_oe=0, bit counter=0, edges ignored. cs_s falling → ACTIVE, load word (see below).
  - ACTIVE: sample edge → shift synchronized MOSI into rx shift register, bit counter +1. Shift edge → advance tx shift register, except the first leading edge of a word when CPHA=1, which only presents bit 0 (CPHA=0 presents bit 0 at word load).
  - Counter reaching DATA_W on a sample edge: o_rx_data ← assembled word, o_rx_valid pulse, counter wraps to 0, next word loaded (continuous transfer while CS low).
  - cs_s rising → IDLE immediately; partial word discarded, no o_rx_valid, tx shift register cleared; holding register untouched.
- Word load: if holding register full, tx shift ← holding, holding marked empty; else tx shift ← 0, o_tx_underrun pulse.
- Holding register: accept when i_tx_valid && o_tx_ready. Same-cycle accept and load: load sees pre-cycle contents (empty → underrun); accepted word stays for next word.
- o_miso = tx shift MSB (LSB if lsb_first); 0 in IDLE.

## Timing
- Reset values: o_miso 0, o_miso_oe 0, o_tx_ready 1, o_rx_data 0, o_rx_valid 0, o_tx_underrun 0, o_busy 0, FSM IDLE.
- Pin edge to internal edge pulse: 3 i_clk cycles. o_rx_valid asserts 1 cycle after the final sample-edge pulse.
- CS_n pin falling to o_miso_oe/o_busy high: 3 cycles; CS_n rising to low: 3 cycles.
- MISO update: 1 cycle after shift-edge pulse (≤4 cycles after pin edge); guaranteed stable at next sample edge given 8× oversampling.
- o_tx_ready deasserts the cycle after accept; reasserts the cycle after load.
- Reset asserted mid-transfer: all state to reset values immediately; after release, transfer resumes only on a fresh CS_n falling edge.

## Test plan
- Mode 0, MSB first, DATA_W=8: tx 0xA5 preloaded, master sends 0x3C → o_rx_data=0x3C with one o_rx_valid pulse; MISO bits 1,0,1,0,0,1,0,1.
- Modes 1, 2, 3 same words → identical results; CPHA=1 MISO bit 0 appears only after first leading edge.
- LSB first, master sends 0x01 → o_rx_data=0x01, first MISO bit = tx bit 0.
- CS low for 24 SCLKs, tx words 0x11,0x22 queued just-in-time, third missing → three o_rx_valid pulses; third MISO word 0x00 with o_tx_underrun pulse.
- CS_n rises after 5 bits → no o_rx_valid, o_busy/o_miso_oe low 3 cycles later; next full transfer correct.
- i_rst pulsed mid-word → all outputs at reset values; new CS cycle receives 0xFF correctly.
